// File: rtl/tile_array_ctrl_if.sv
// Scheduler/fmap-buffer/array control bundle for tile_array_ctrl.
// With TILE_ARRAY_CTRL_PERF_EN defined the bundle also carries o_stall_cnt.
interface tile_array_ctrl_if #(
  parameter int unsigned CNT_BW = 16
);
  logic              i_start;
  logic [2:0]        i_layer;
  logic [CNT_BW-1:0] i_num_vec;
  logic              i_abort;
  logic              i_fmap_valid;
  logic              o_fmap_ready;
  logic              o_w_rd_en;
  logic              o_en_tf;
  logic [1:0]        o_cal_state;
  logic [2:0]        o_layer_state;
  logic              o_busy;
  logic              o_result_valid;
  logic              o_done;
`ifdef TILE_ARRAY_CTRL_PERF_EN
  logic [CNT_BW-1:0] o_stall_cnt;

  modport master (
    output i_start, i_layer, i_num_vec, i_abort, i_fmap_valid,
    input  o_fmap_ready, o_w_rd_en, o_en_tf, o_cal_state, o_layer_state,
           o_busy, o_result_valid, o_done, o_stall_cnt
  );
  modport slave (
    input  i_start, i_layer, i_num_vec, i_abort, i_fmap_valid,
    output o_fmap_ready, o_w_rd_en, o_en_tf, o_cal_state, o_layer_state,
           o_busy, o_result_valid, o_done, o_stall_cnt
  );
`else
  modport master (
    output i_start, i_layer, i_num_vec, i_abort, i_fmap_valid,
    input  o_fmap_ready, o_w_rd_en, o_en_tf, o_cal_state, o_layer_state,
           o_busy, o_result_valid, o_done
  );
  modport slave (
    input  i_start, i_layer, i_num_vec, i_abort, i_fmap_valid,
    output o_fmap_ready, o_w_rd_en, o_en_tf, o_cal_state, o_layer_state,
           o_busy, o_result_valid, o_done
  );
`endif
endinterface

// File: rtl/tile_array_ctrl.sv
// Systolic tile array sequencer: weight load, fmap streaming, pipeline drain.
// Optional stall counter (o_stall_cnt) enabled by defining TILE_ARRAY_CTRL_PERF_EN.
module tile_array_ctrl #(
  parameter int unsigned ROWS   = 5,
  parameter int unsigned COLS   = 5,
  parameter int unsigned T_ROWS = 5,
  parameter int unsigned T_COLS = 5,
  parameter int unsigned CNT_BW = 16
) (
  input logic             clk,
  input logic             rst,
  tile_array_ctrl_if.slave bus
);
  localparam logic [CNT_BW-1:0] W_CYC  = CNT_BW'(ROWS * T_ROWS);
  localparam logic [CNT_BW-1:0] W_LAST = CNT_BW'(ROWS * T_ROWS - 1);
  localparam logic [CNT_BW-1:0] D_LAST = CNT_BW'(ROWS * T_ROWS + COLS * T_COLS - 2);

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    LOAD_W  = 2'b01,
    COMPUTE = 2'b10,
    DRAIN   = 2'b11
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_BW-1:0] cnt_q, cnt_d;
  logic [CNT_BW-1:0] vec_cnt_q, vec_cnt_d;
  logic [CNT_BW-1:0] num_vec_q, num_vec_d;
  logic [2:0]        layer_q, layer_d;

  logic fmap_ready, w_rd_en, en_tf, result_valid, done;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      vec_cnt_q <= '0;
      num_vec_q <= '0;
      layer_q   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      vec_cnt_q <= vec_cnt_d;
      num_vec_q <= num_vec_d;
      layer_q   <= layer_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    vec_cnt_d    = vec_cnt_q;
    num_vec_d    = num_vec_q;
    layer_d      = layer_q;
    fmap_ready   = 1'b0;
    w_rd_en      = 1'b0;
    en_tf        = 1'b0;
    result_valid = 1'b0;
    done         = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.i_start) begin
          layer_d   = bus.i_layer;
          num_vec_d = bus.i_num_vec;
          cnt_d     = '0;
          vec_cnt_d = '0;
          state_d   = LOAD_W;
        end
      end
      LOAD_W: begin
        w_rd_en = 1'b1;
        en_tf   = 1'b1;
        if (cnt_q == W_LAST) begin
          cnt_d   = '0;
          state_d = (num_vec_q == '0) ? DRAIN : COMPUTE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      COMPUTE: begin
        fmap_ready = 1'b1;
        en_tf      = bus.i_fmap_valid;
        if (bus.i_fmap_valid) begin
          result_valid = (vec_cnt_q >= W_CYC);
          vec_cnt_d    = vec_cnt_q + 1'b1;
          // compare against num_vec-1 so an all-ones vector count never wraps
          if (vec_cnt_q == num_vec_q - 1'b1) begin
            cnt_d   = '0;
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        en_tf        = 1'b1;
        result_valid = 1'b1;
        if (cnt_q == D_LAST) begin
          done    = 1'b1;
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (state_q != IDLE && bus.i_abort) begin
      state_d   = IDLE;
      cnt_d     = '0;
      vec_cnt_d = '0;
      done      = 1'b0;
    end
  end

  assign bus.o_fmap_ready   = fmap_ready;
  assign bus.o_w_rd_en      = w_rd_en;
  assign bus.o_en_tf        = en_tf;
  assign bus.o_cal_state    = state_q;
  assign bus.o_layer_state  = (state_q == IDLE) ? 3'b000 : layer_q;
  assign bus.o_busy         = (state_q != IDLE);
  assign bus.o_result_valid = result_valid;
  assign bus.o_done         = done;

`ifdef TILE_ARRAY_CTRL_PERF_EN
  logic [CNT_BW-1:0] stall_q, stall_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) stall_q <= '0;
    else     stall_q <= stall_d;
  end

  always_comb begin
    stall_d = stall_q;
    if (state_q == IDLE && bus.i_start)
      stall_d = '0;
    else if (state_q == COMPUTE && !bus.i_fmap_valid && stall_q != '1)
      stall_d = stall_q + 1'b1;
  end

  assign bus.o_stall_cnt = stall_q;
`else
  // no stall counter in this build
`endif
endmodule
